// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak lane width, rate constants and squeeze FSM states
package keccak_pkg;
  localparam int W = 64;
  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;
  typedef enum logic [1:0] {IDLE, STREAM, PERM_REQ, PERM_WAIT} squeeze_state_e;
endpackage

// File: rtl/keccak_squeeze_if.sv
// keccak_squeeze_if: state-in, lane-out and re-permutation handshakes (xof_lanes only with KECCAK_SQUEEZE_XOF_EN)
interface keccak_squeeze_if #(
  parameter int W = keccak_pkg::W,
  parameter int B = 25 * W
);
  logic s_valid;
  logic s_ready;
  logic [B-1:0] s_state;
  logic m_valid;
  logic m_ready;
  logic [W-1:0] m_data;
  logic m_last;
  logic p_req_valid;
  logic p_req_ready;
  logic [B-1:0] p_req_state;
  logic p_rsp_valid;
  logic [B-1:0] p_rsp_state;
`ifdef KECCAK_SQUEEZE_XOF_EN
  logic [15:0] xof_lanes;
`endif
  modport slave (
`ifdef KECCAK_SQUEEZE_XOF_EN
    input xof_lanes,
`endif
    input s_valid, s_state, m_ready, p_req_ready, p_rsp_valid, p_rsp_state,
    output s_ready, m_valid, m_data, m_last, p_req_valid, p_req_state
  );
  modport master (
`ifdef KECCAK_SQUEEZE_XOF_EN
    output xof_lanes,
`endif
    output s_valid, s_state, m_ready, p_req_ready, p_rsp_valid, p_rsp_state,
    input s_ready, m_valid, m_data, m_last, p_req_valid, p_req_state
  );
endinterface

// File: rtl/keccak_lane_select.sv
// keccak_lane_select: picks lane n = 5*y + x out of a flat Keccak state
module keccak_lane_select #(
  parameter int W = 64,
  parameter int B = 25 * W
) (
  input  logic [B-1:0] state,
  input  logic [4:0]   idx,
  output logic [W-1:0] lane
);
  logic [W-1:0] lanes [25];
  for (genvar n = 0; n < 25; n++) begin : g_lane
    assign lanes[n] = state[W*n +: W];
  end
  assign lane = (idx < 5'd25) ? lanes[idx] : '0;
endmodule

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams a permuted state as w-bit lanes, re-permuting when the rate runs out; KECCAK_SQUEEZE_XOF_EN adds a per-digest length
module keccak_squeeze #(
  parameter int L = 6,
  parameter int W = 2 ** L,
  parameter int B = 25 * W,
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES = 4
) (
  input logic clk,
  input logic rst_n,
  keccak_squeeze_if.slave bus
);
  import keccak_pkg::*;
  squeeze_state_e state;
  logic [B-1:0] held;
  logic [4:0] idx;
  logic [15:0] rem;
  logic [15:0] len;
  logic s_ready;
  logic m_valid;
  logic m_last;
  logic p_req_valid;
`ifdef KECCAK_SQUEEZE_XOF_EN
  assign len = bus.xof_lanes;
`else
  assign len = 16'(OUT_LANES);
`endif
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_last = m_last;
  assign bus.p_req_valid = p_req_valid;
  assign bus.p_req_state = held;
  keccak_lane_select #(.W(W), .B(B)) u_sel (
    .state(held),
    .idx(idx),
    .lane(bus.m_data)
  );
  // squeeze sequencing with registered handshake outputs; rem==0 in STREAM only arises from a zero-length XOF request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      held <= '0;
      idx <= '0;
      rem <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      p_req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.s_valid) begin
          held <= bus.s_state;
          idx <= '0;
          rem <= len;
          s_ready <= 1'b0;
          m_valid <= len != 16'd0;
          m_last <= len == 16'd1;
          state <= STREAM;
        end
        STREAM: if (rem == 16'd0) begin
          s_ready <= 1'b1;
          state <= IDLE;
        end else if (bus.m_ready) begin
          if (rem == 16'd1) begin
            m_valid <= 1'b0;
            m_last <= 1'b0;
            s_ready <= 1'b1;
            state <= IDLE;
          end else if (idx == 5'(RATE_LANES - 1)) begin
            rem <= rem - 16'd1;
            m_valid <= 1'b0;
            m_last <= 1'b0;
            p_req_valid <= 1'b1;
            state <= PERM_REQ;
          end else begin
            idx <= idx + 5'd1;
            rem <= rem - 16'd1;
            m_last <= rem == 16'd2;
          end
        end
        PERM_REQ: if (bus.p_req_ready) begin
          p_req_valid <= 1'b0;
          state <= PERM_WAIT;
        end
        PERM_WAIT: if (bus.p_rsp_valid) begin
          held <= bus.p_rsp_state;
          idx <= '0;
          m_valid <= 1'b1;
          m_last <= rem == 16'd1;
          state <= STREAM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze: random traffic against three squeeze configurations checked by a lane-level digest model
module tb_keccak_squeeze;
  localparam int NCYC = 4000;
  localparam int RST_CYC = 2000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int RL = (g == 0) ? 17 : (g == 1) ? 2 : 4;
    localparam int OL = (g == 1) ? 5 : 4;
    keccak_squeeze_if #(.W(64)) bus ();
    keccak_squeeze #(.RATE_LANES(RL), .OUT_LANES(OL)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
    initial begin
      logic [63:0] cur [25];
      logic [1599:0] nxt, rsp;
      bit busy, in_perm, req_done, sv, mr, prr, prv, exp_mv, exp_pv;
      int k, rem, len, ndig;
      string p;
      busy = 0; in_perm = 0; req_done = 0; k = 0; rem = 0; len = OL; ndig = 0;
      p = $sformatf("u%0d", g);
      bus.s_valid = 0; bus.s_state = '0; bus.m_ready = 0;
      bus.p_req_ready = 0; bus.p_rsp_valid = 0; bus.p_rsp_state = '0;
`ifdef KECCAK_SQUEEZE_XOF_EN
      bus.xof_lanes = 16'(OL);
`endif
      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #3;
        if (!rst_n) begin
          busy = 0; in_perm = 0; req_done = 0;
          check({p, " rst s_ready"}, 64'(bus.s_ready), 64'd1);
          check({p, " rst m_valid"}, 64'(bus.m_valid), 64'd0);
          check({p, " rst m_last"}, 64'(bus.m_last), 64'd0);
          check({p, " rst m_data"}, bus.m_data, 64'd0);
          check({p, " rst p_req_valid"}, 64'(bus.p_req_valid), 64'd0);
          check({p, " rst p_req_state"}, 64'(|bus.p_req_state), 64'd0);
        end else begin
          exp_mv = busy && !in_perm && rem > 0;
          exp_pv = in_perm && !req_done;
          check({p, " s_ready"}, 64'(bus.s_ready), 64'(!busy));
          check({p, " m_valid"}, 64'(bus.m_valid), 64'(exp_mv));
          check({p, " p_req_valid"}, 64'(bus.p_req_valid), 64'(exp_pv));
          if (exp_mv) begin
            check({p, " m_data"}, bus.m_data, cur[k]);
            check({p, " m_last"}, 64'(bus.m_last), 64'(rem == 1));
          end
          if (exp_pv)
            for (int n = 0; n < 25; n++) check({p, " p_req_state"}, bus.p_req_state[64*n +: 64], cur[n]);
        end
        for (int n = 0; n < 50; n++) begin
          nxt[32*n +: 32] = $urandom();
          rsp[32*n +: 32] = $urandom();
        end
        if (ndig == 0)
          for (int n = 0; n < 25; n++) nxt[64*n +: 64] = 64'(n + 1) * 64'h0001_0001_0001_0001;
        sv = $urandom_range(0, 2) != 0;
        mr = $urandom_range(0, 3) != 0;
        prr = $urandom_range(0, 2) == 0;
        prv = $urandom_range(0, 2) == 0;
`ifdef KECCAK_SQUEEZE_XOF_EN
        len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3 * RL + 2));
        bus.xof_lanes = 16'(len);
`else
        len = OL;
`endif
        bus.s_valid = sv; bus.s_state = nxt; bus.m_ready = mr;
        bus.p_req_ready = prr; bus.p_rsp_valid = prv; bus.p_rsp_state = rsp;
        if (rst_n) begin
          if (!busy) begin
            if (sv) begin
              for (int n = 0; n < 25; n++) cur[n] = nxt[64*n +: 64];
              busy = 1; k = 0; rem = len; ndig++;
            end
          end else if (in_perm) begin
            if (!req_done) req_done = prr;
            else if (prv) begin
              for (int n = 0; n < 25; n++) cur[n] = rsp[64*n +: 64];
              k = 0; in_perm = 0;
            end
          end else if (rem == 0) busy = 0;
          else if (mr) begin
            k++; rem--;
            if (rem == 0) busy = 0;
            else if (k == RL) begin in_perm = 1; req_done = 0; end
          end
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (RST_CYC) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (NCYC) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
- Output end of the Keccak sponge: accepts a permuted b-bit state and streams the digest as w-bit lanes over a valid/ready interface.
- Flat state bit order: lane n = 5*y + x occupies bits [w*n +: w], matching the state packing used by the round block.
- When the rate portion is exhausted and more output is needed, it sends the state back to the permutation engine and resumes on the returned state.
- Sits between the iterative Keccak-f engine and the hash output port (SHA3 fixed output; SHAKE when the optional feature is enabled).

Parameters:
- l, 6, log2 lane width.
- w, 2**l, lane width in bits.
- b, 25*w, state width.
- RATE_LANES, 17, lanes output per permutation (r/w); legal range 1..24.
- OUT_LANES, 4, lanes per digest (fixed-length mode); must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input state valid.
- s_ready  out  1  input state ready.
- s_state  in  b  permuted state.
- m_valid  out  1  output lane valid.
- m_ready  in  1  output lane ready.
- m_data  out  w  output lane.
- m_last  out  1  final lane of the digest.
- p_req_valid  out  1  re-permutation request valid.
- p_req_ready  in  1  permutation engine accepts the request.
- p_req_state  out  b  state to permute (the held state).
- p_rsp_valid  in  1  permuted state returned (always accepted in PERM_WAIT).
- p_rsp_state  in  b  returned state.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: FSM=IDLE, held state=0, lane index=0, remaining=0. Therefore s_ready=1, m_valid=0, m_last=0, m_data=0, p_req_valid=0, p_req_state=0.
- Registers: held state (b), lane index idx (5 bits), remaining count rem (16 bits).
- IDLE: s_ready=1. On s_valid, capture s_state, set idx=0 and rem=OUT_LANES, go to STREAM.
- STREAM: m_valid=1, m_data=lane idx of the held state, m_last=(rem==1). m_data and m_last stay stable until the handshake. On m_valid&&m_ready:
  - rem==1 -> IDLE.
  - else if idx==RATE_LANES-1 -> PERM_REQ, rem--.
  - else idx++, rem--.
- PERM_REQ: p_req_valid=1, p_req_state=held state. On p_req_ready -> PERM_WAIT.
- PERM_WAIT: on p_rsp_valid, capture p_rsp_state, set idx=0, go to STREAM.
- Latency: input handshake in cycle N gives the first m_valid in N+1. Throughput is 1 lane/cycle while m_ready=1. Each re-permutation adds at least 2 cycles plus engine latency.
- s_ready=0 outside IDLE, and s_valid is ignored there. p_rsp_valid outside PERM_WAIT is ignored.
- When OUT_LANES equals RATE_LANES exactly, no permutation is requested: the last lane goes to IDLE.
- Reset mid-operation aborts immediately: no request stays asserted, and a late p_rsp_valid after reset is ignored.
- Back-to-back digests: a new s_valid is accepted in the cycle after the last-lane handshake, never in the same cycle.

Optional Feature:
- Macro: KECCAK_SQUEEZE_XOF_EN.
- Defined: adds input port xof_lanes (16 bits), sampled with the s_state handshake, which replaces OUT_LANES for that digest.
  - xof_lanes==0: the state is accepted, no lanes are produced, FSM returns to IDLE the next cycle.
- Not defined: port absent, length is always OUT_LANES.

Decomposition:
- keccak_pkg holds:
  - lane width constant W=64.
  - RATE_LANES constants for SHA3_224/256/384/512 and SHAKE128/256 (18, 17, 13, 9, 21, 17).
  - enum squeeze_state_e {IDLE, STREAM, PERM_REQ, PERM_WAIT}.
- One combinational sub-module, keccak_lane_select (flat b-bit state + 5-bit lane index -> w-bit lane), is also reused by the absorb side.

Test Plan:
- Basic digest: state with lane n = (n+1)*64'h0001_0001_0001_0001, OUT_LANES=4, m_ready=1 -> lanes 0x0001..0001, 0x0002..0002, 0x0003..0003, 0x0004..0004 in consecutive cycles; m_last only on the 4th; s_ready=0 throughout, then 1.
- Backpressure: m_ready toggling 1,0,0,1 -> m_data/m_last hold during stalls; no lane skipped or duplicated.
- Re-permutation: RATE_LANES=2, OUT_LANES=5 -> 2 lanes, then p_req_valid with p_req_state equal to the held state. With p_req_ready after 3 cycles and response lane n = 0x100+n, the next lanes are 0x100, 0x101, then a second request, then 0x100 with m_last.
- Exact fit: RATE_LANES=4, OUT_LANES=4 -> p_req_valid never asserts.
- Reset mid-stream: rst_n low after lane 1, held for 1 cycle -> m_valid=0 and s_ready=1 immediately; the next digest starts at lane 0.
- XOF (macro on): xof_lanes=0 -> no m_valid, s_ready back to 1 after 1 cycle. xof_lanes=21 with RATE_LANES=21 -> exactly 21 lanes, no request.
